// File: rtl/operand_join_if.sv
// Handshake bundle between the two operand producers, the join stage and the PE function cell.
interface operand_join_if #(
  parameter int size = 32
);
  logic [size-1:0] in0;
  logic            in0_valid;
  logic            in0_ready;
  logic [size-1:0] in1;
  logic            in1_valid;
  logic            in1_ready;
  logic [size-1:0] out0;
  logic [size-1:0] out1;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in0, in0_valid, in1, in1_valid, out_ready,
    input  in0_ready, in1_ready, out0, out1, out_valid
  );

  modport slave (
    input  in0, in0_valid, in1, in1_valid, out_ready,
    output in0_ready, in1_ready, out0, out1, out_valid
  );
endinterface

// File: rtl/operand_join.sv
// Buffers two operand streams in per-operand FIFOs and emits aligned pairs on a registered
// valid/ready output; config_sig selects single-operand mode and output swap.
module operand_join #(
  parameter int size  = 32,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     config_sig,
  operand_join_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [size-1:0] memA_q [DEPTH];
  logic [size-1:0] memB_q [DEPTH];
  logic [AW-1:0]   wrPtrA_q, wrPtrA_d, rdPtrA_q, rdPtrA_d;
  logic [AW-1:0]   wrPtrB_q, wrPtrB_d, rdPtrB_q, rdPtrB_d;
  logic [CW-1:0]   countA_q, countA_d, countB_q, countB_d;
  logic [size-1:0] out0_q, out0_d, out1_q, out1_d;
  logic            outValid_q, outValid_d;

  logic            singleMode, swapOut;
  logic            pushA, pushB, popA, popB;
  logic            loadOk, fire;
  logic [size-1:0] headA, headB, pairFirst, pairSecond;

  assign singleMode = config_sig[0];
  assign swapOut    = config_sig[1];

  // Ready depends only on registered counts, so there is no path from out_ready.
  assign bus.in0_ready = (countA_q != FULL);
  assign bus.in1_ready = (countB_q != FULL) && !singleMode;

  assign pushA = bus.in0_valid && bus.in0_ready;
  assign pushB = bus.in1_valid && bus.in1_ready;

  assign loadOk = !outValid_q || bus.out_ready;
  assign fire   = loadOk && (countA_q != '0) && (singleMode || (countB_q != '0));
  assign popA   = fire;
  assign popB   = fire && !singleMode;

  assign headA      = memA_q[rdPtrA_q];
  assign headB      = memB_q[rdPtrB_q];
  assign pairFirst  = headA;
  assign pairSecond = singleMode ? '0 : headB;

  always_comb begin
    wrPtrA_d = pushA ? wrPtrA_q + AW'(1) : wrPtrA_q;
    rdPtrA_d = popA  ? rdPtrA_q + AW'(1) : rdPtrA_q;
    wrPtrB_d = pushB ? wrPtrB_q + AW'(1) : wrPtrB_q;
    rdPtrB_d = popB  ? rdPtrB_q + AW'(1) : rdPtrB_q;

    countA_d = countA_q;
    if (pushA && !popA) begin
      countA_d = countA_q + CW'(1);
    end else if (!pushA && popA) begin
      countA_d = countA_q - CW'(1);
    end

    countB_d = countB_q;
    if (pushB && !popB) begin
      countB_d = countB_q + CW'(1);
    end else if (!pushB && popB) begin
      countB_d = countB_q - CW'(1);
    end
  end

  // Output stage: load on fire, drop valid once consumed, otherwise hold.
  always_comb begin
    out0_d     = out0_q;
    out1_d     = out1_q;
    outValid_d = outValid_q;
    if (fire) begin
      out0_d     = swapOut ? pairSecond : pairFirst;
      out1_d     = swapOut ? pairFirst  : pairSecond;
      outValid_d = 1'b1;
    end else if (outValid_q && bus.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pushA) begin
      memA_q[wrPtrA_q] <= bus.in0;
    end
    if (pushB) begin
      memB_q[wrPtrB_q] <= bus.in1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtrA_q   <= '0;
      rdPtrA_q   <= '0;
      wrPtrB_q   <= '0;
      rdPtrB_q   <= '0;
      countA_q   <= '0;
      countB_q   <= '0;
      out0_q     <= '0;
      out1_q     <= '0;
      outValid_q <= 1'b0;
    end else begin
      wrPtrA_q   <= wrPtrA_d;
      rdPtrA_q   <= rdPtrA_d;
      wrPtrB_q   <= wrPtrB_d;
      rdPtrB_q   <= rdPtrB_d;
      countA_q   <= countA_d;
      countB_q   <= countB_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      outValid_q <= outValid_d;
    end
  end

  assign bus.out0      = out0_q;
  assign bus.out1      = out1_q;
  assign bus.out_valid = outValid_q;

endmodule

// File: tb/tb_operand_join.sv
// Directed bench for operand_join: expected pairs are queued as stimulus is issued and a
// negedge monitor pops and compares every accepted output pair.
module tb_operand_join;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] config_sig;

  operand_join_if #(.size(32)) bus ();

  operand_join #(.size(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .config_sig (config_sig),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] expQ [$];
  logic [63:0] expPair;
  int          passCount  = 0;
  int          checkCount = 0;
  int          xferCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Monitor: every accepted pair must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      xferCount++;
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected pair: got %h, expected none", {bus.out0, bus.out1});
      end else begin
        expPair = expQ.pop_front();
        checkOutput("pair", {bus.out0, bus.out1}, expPair);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic aValid, input logic [31:0] a,
                               input logic bValid, input logic [31:0] b);
    bus.in0_valid = aValid;
    bus.in0       = a;
    bus.in1_valid = bValid;
    bus.in1       = b;
    tick();
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while ((expQ.size() != 0 || bus.out_valid) && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("drain pending", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int aSent, bSent, accepted, startX;
    logic accA, accB;

    rst_n         = 1'b0;
    config_sig    = 2'b00;
    bus.in0       = '0;
    bus.in0_valid = 1'b0;
    bus.in1       = '0;
    bus.in1_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset outs", {bus.out0, bus.out1}, 64'd0);
    checkOutput("reset readies", 64'({bus.in0_ready, bus.in1_ready}), 64'd3);

    // Mid-traffic reset: buffered pairs must never appear afterwards.
    applyStimulus(1'b1, 32'h11, 1'b1, 32'h22);
    applyStimulus(1'b1, 32'h33, 1'b1, 32'h44);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("pre-reset valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("post-reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("post-reset outs", {bus.out0, bus.out1}, 64'd0);
    checkOutput("post-reset readies", 64'({bus.in0_ready, bus.in1_ready}), 64'd3);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    checkOutput("post-reset idle", 64'(bus.out_valid), 64'd0);

    // Skewed join: A arrives first, each pair valid the cycle after its B.
    expQ.push_back({32'd5, 32'd10});
    expQ.push_back({32'd6, 32'd20});
    expQ.push_back({32'd7, 32'd30});
    applyStimulus(1'b1, 32'd5, 1'b0, 32'd0);
    applyStimulus(1'b1, 32'd6, 1'b0, 32'd0);
    applyStimulus(1'b1, 32'd7, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 32'd10);
    checkOutput("skew latency N", 64'(bus.out_valid), 64'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 32'd20);
    checkOutput("skew latency N+1", 64'(bus.out_valid), 64'd1);
    checkOutput("skew first pair", {bus.out0, bus.out1}, {32'd5, 32'd10});
    applyStimulus(1'b0, 32'd0, 1'b1, 32'd30);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    waitDrain(20);

    // Backpressure: one pair latched, both FIFOs fill to four.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) expQ.push_back({32'(100 + i), 32'(200 + i)});
    aSent = 0;
    bSent = 0;
    for (int c = 0; c < 8; c++) begin
      accA = (aSent < 6) && bus.in0_ready;
      accB = (bSent < 6) && bus.in1_ready;
      applyStimulus(aSent < 6, 32'(100 + aSent), bSent < 6, 32'(200 + bSent));
      if (accA) aSent++;
      if (accB) bSent++;
    end
    checkOutput("full A accepted", 64'(aSent), 64'd5);
    checkOutput("full B accepted", 64'(bSent), 64'd5);
    checkOutput("full readies", 64'({bus.in0_ready, bus.in1_ready}), 64'd0);
    checkOutput("full out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("full held pair", {bus.out0, bus.out1}, {32'd100, 32'd200});

    // Release while full and offering data: pop happens, push does not.
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 32'd105, 1'b1, 32'd205);
    checkOutput("release readies", 64'({bus.in0_ready, bus.in1_ready}), 64'd3);
    applyStimulus(1'b1, 32'd105, 1'b1, 32'd205);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    waitDrain(30);

    // Single mode with swap.
    tick();
    config_sig = 2'b11;
    #1;
    checkOutput("single in1_ready", 64'(bus.in1_ready), 64'd0);
    expQ.push_back({32'd0, 32'hDEADBEEF});
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 32'h12345678);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("single out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("single swapped", {bus.out0, bus.out1}, {32'd0, 32'hDEADBEEF});
    checkOutput("single in1_ready held", 64'(bus.in1_ready), 64'd0);
    waitDrain(20);
    tick();
    config_sig = 2'b00;
    tick();

    // Streaming: one pair per cycle.
    for (int i = 0; i < 20; i++) expQ.push_back({32'(i * 3 + 1), 32'(i * 7 + 2)});
    accepted = 0;
    startX   = xferCount;
    for (int i = 0; i < 20; i++) begin
      if (bus.in0_ready && bus.in1_ready) accepted++;
      applyStimulus(1'b1, 32'(i * 3 + 1), 1'b1, 32'(i * 7 + 2));
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    checkOutput("stream accepted", 64'(accepted), 64'd20);
    checkOutput("stream transfers", 64'(xferCount - startX), 64'd20);
    waitDrain(30);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
